// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
// System-bus side of the cache/bus arbiter: request channel (address and
// write-data beats) and response channel (read-data beats).
//
// Signals
//   bus_reqcyc   request beat valid            (arbiter -> bus)
//   bus_req      address or write-data beat    (arbiter -> bus)
//   bus_reqtag   {op, target, 8'h00}           (arbiter -> bus)
//   bus_reqack   bus accepted the request beat (bus -> arbiter)
//   bus_respcyc  response beat valid           (bus -> arbiter)
//   bus_respack  response beat accepted        (arbiter -> bus)
//   bus_resp     response data                 (bus -> arbiter)
//   bus_resptag  response tag                  (bus -> arbiter)
//
// Modports
//   master : the arbiter
//   slave  : the bus / memory model
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
);
    logic                      bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_reqack;
    logic                      bus_respcyc;
    logic                      bus_respack;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;

    modport master (
        output bus_reqcyc,
        output bus_req,
        output bus_reqtag,
        output bus_respack,
        input  bus_reqack,
        input  bus_respcyc,
        input  bus_resp,
        input  bus_resptag
    );

    modport slave (
        input  bus_reqcyc,
        input  bus_req,
        input  bus_reqtag,
        input  bus_respack,
        output bus_reqack,
        output bus_respcyc,
        output bus_resp,
        output bus_resptag
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Arbitrates block requests from the instruction and data caches onto the
// system bus. Each transfer is one address beat followed by BEATS data beats:
// reads are cache-line fills returned as one BLOCKSZ-bit block with a
// one-cycle valid pulse, writes are dirty-line writebacks.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   i_req/i_addr        icache fill request (level, held until i_valid)
//   i_valid             one-cycle pulse: blk_data holds the icache fill
//   d_req/d_we/d_addr   dcache request; d_we=1 writeback, 0 fill
//   d_wdata             writeback block, captured at grant
//   d_valid             one-cycle pulse: dcache fill ready / writeback done
//   blk_data            last completed fill block
//   bus                 system bus (mem_bus_arbiter_if.master)
//
// Configuration
//   ROUND_ROBIN_EN  undefined: dcache has fixed priority on a tie.
//                   defined:   a tie goes to the client not served last.
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_W         = 64,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BLOCKSZ        = 512
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_req,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic               i_valid,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [BLOCKSZ-1:0] d_wdata,
    output logic               d_valid,
    output logic [BLOCKSZ-1:0] blk_data,
    mem_bus_arbiter_if.master  bus
);

    localparam int BEATS  = BLOCKSZ / BUS_DATA_WIDTH;
    localparam int BEAT_W = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [3:0]        TAG_MEMORY = 4'b0001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_RESP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_r;
    logic                grant_d_r;   // 1 = dcache owns the current transfer
    logic                op_read_r;   // 1 = fill, 0 = writeback
    logic [BLOCKSZ-1:0]  wdata_r;     // writeback block, shifted down one word per beat
    logic [BLOCKSZ-1:0]  fill_buf_r;  // fill assembly, words shifted in from the top
    logic [BEAT_W-1:0]   beat_r;
    logic                grant_d_s;
    logic                grant_read_s;
    logic                unused_bits_s;

    // Align an address to the start of its 64-byte block.
    function automatic logic [ADDR_W-1:0] block_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:6], 6'b000000};
    endfunction

    // Response tags are not checked; the low address bits are forced to zero.
    assign unused_bits_s = ^{bus.bus_resptag, i_addr[5:0], d_addr[5:0]};

`ifdef ROUND_ROBIN_EN
    logic last_d_r;  // 1 = dcache won the most recent grant

    // Remember the most recent winner so that ties alternate between clients.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_d_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && (i_req || d_req)) begin
            last_d_r <= grant_d_s;
        end
    end
`endif

    // Pick the winner among the pending requests seen in IDLE.
    always_comb begin
        grant_d_s = 1'b0;
        if (d_req && i_req) begin
`ifdef ROUND_ROBIN_EN
            grant_d_s = ~last_d_r;
`else
            grant_d_s = 1'b1;
`endif
        end else if (d_req) begin
            grant_d_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
        end
    end

    // An icache grant is always a fill; a dcache grant follows d_we.
    always_comb begin
        grant_read_s = 1'b1;
        if (grant_d_s) begin
            grant_read_s = ~d_we;
        end else begin
            grant_read_s = 1'b1;
        end
    end

    // Response beats are only accepted while a fill is collecting data.
    assign bus.bus_respack = (state_r == ST_RESP) ? bus.bus_respcyc : 1'b0;

    // Transfer sequencer: grant, address beat, data beats, completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            grant_d_r      <= 1'b0;
            op_read_r      <= 1'b0;
            wdata_r        <= '0;
            fill_buf_r     <= '0;
            beat_r         <= '0;
            i_valid        <= 1'b0;
            d_valid        <= 1'b0;
            blk_data       <= '0;
            bus.bus_reqcyc <= 1'b0;
            bus.bus_req    <= '0;
            bus.bus_reqtag <= '0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        grant_d_r      <= grant_d_s;
                        op_read_r      <= grant_read_s;
                        wdata_r        <= d_wdata;
                        beat_r         <= '0;
                        bus.bus_reqcyc <= 1'b1;
                        bus.bus_req    <= grant_d_s ? block_align(d_addr) : block_align(i_addr);
                        bus.bus_reqtag <= {grant_read_s, TAG_MEMORY, 8'h00};
                        state_r        <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (bus.bus_reqack) begin
                        if (op_read_r) begin
                            bus.bus_reqcyc <= 1'b0;
                            bus.bus_req    <= '0;
                            bus.bus_reqtag <= '0;
                            state_r        <= ST_RESP;
                        end else begin
                            // First data word goes out right behind the address.
                            bus.bus_req <= wdata_r[BUS_DATA_WIDTH-1:0];
                            wdata_r     <= wdata_r >> BUS_DATA_WIDTH;
                            state_r     <= ST_WDATA;
                        end
                    end
                end
                ST_WDATA: begin
                    if (bus.bus_reqack) begin
                        if (beat_r == LAST_BEAT) begin
                            bus.bus_reqcyc <= 1'b0;
                            bus.bus_req    <= '0;
                            bus.bus_reqtag <= '0;
                            beat_r         <= '0;
                            state_r        <= ST_DONE;
                        end else begin
                            bus.bus_req <= wdata_r[BUS_DATA_WIDTH-1:0];
                            wdata_r     <= wdata_r >> BUS_DATA_WIDTH;
                            beat_r      <= beat_r + 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (bus.bus_respcyc) begin
                        // Word 0 arrives first; after BEATS shifts it sits at the bottom.
                        fill_buf_r <= {bus.bus_resp, fill_buf_r[BLOCKSZ-1:BUS_DATA_WIDTH]};
                        if (beat_r == LAST_BEAT) begin
                            beat_r  <= '0;
                            state_r <= ST_DONE;
                        end else begin
                            beat_r <= beat_r + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (grant_d_r) begin
                        d_valid <= 1'b1;
                    end else begin
                        i_valid <= 1'b1;
                    end
                    // Writebacks leave the last fill block visible.
                    if (op_read_r) begin
                        blk_data <= fill_buf_r;
                    end
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
    localparam int ADDR_W = 64;
    localparam int W      = 64;
    localparam int T      = 13;
    localparam int BLK    = 512;
    localparam int BEATS  = 8;
    localparam logic [T-1:0] READ_TAG  = 13'h1100;
    localparam logic [T-1:0] WRITE_TAG = 13'h0100;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_req, i_valid, d_req, d_we, d_valid;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [BLK-1:0]    d_wdata, blk_data;

    mem_bus_arbiter_if #(.BUS_DATA_WIDTH(W), .BUS_TAG_WIDTH(T)) bif();

    mem_bus_arbiter #(
        .ADDR_W(ADDR_W), .BUS_DATA_WIDTH(W), .BUS_TAG_WIDTH(T), .BLOCKSZ(BLK)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_valid(d_valid),
        .blk_data(blk_data),
        .bus(bif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    typedef struct packed { logic [W-1:0] data; logic [T-1:0] tag; } bus_exp_t;
    typedef struct packed { logic is_d; logic [BLK-1:0] blk; } resp_exp_t;
    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];
    logic [BLK-1:0] model_blk = '0;

    // bus model controls
    int ack_delay = 0;
    int gap_at = 99;
    int gap_len = 0;
    bit stray_resp = 1'b0;
    bit slave_in_resp = 1'b0;
    int slave_rbeat = 0;

    task automatic check(input string name, input logic [BLK-1:0] act, input logic [BLK-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [BLK-1:0] words(input logic [63:0] base);
        logic [BLK-1:0] r;
        for (int k = 0; k < BEATS; k++) r[64*k +: 64] = base + 64'(k);
        return r;
    endfunction

    // Push the expected bus beats and completion of one transfer.
    task automatic expect_txn(input logic is_d, input logic we, input logic [63:0] addr,
                              input logic [BLK-1:0] wdata, input logic [63:0] base);
        bus_exp_t b;
        resp_exp_t r;
        b.data = addr; b.tag = we ? WRITE_TAG : READ_TAG;
        bus_q.push_back(b);
        if (we) begin
            for (int k = 0; k < BEATS; k++) begin
                b.data = wdata[64*k +: 64]; b.tag = WRITE_TAG;
                bus_q.push_back(b);
            end
        end else begin
            model_blk = words(base);
        end
        r.is_d = is_d; r.blk = model_blk;
        resp_q.push_back(r);
    endtask

    // Clients drop their request in the cycle they see their valid.
    task automatic wait_done(input bit want_i, input bit want_d, output int cycles);
        bit pend_i, pend_d;
        cycles = 0; pend_i = want_i; pend_d = want_d;
        while ((pend_i || pend_d) && cycles < 400) begin
            @(posedge clk); #1; cycles++;
            if (i_valid && pend_i) begin i_req = 1'b0; pend_i = 1'b0; end
            if (d_valid && pend_d) begin d_req = 1'b0; d_we = 1'b0; pend_d = 1'b0; end
        end
        if (pend_i || pend_d) begin
            checks++;
            $display("FAIL wait_done timeout: pending i=%0d d=%0d required none", pend_i, pend_d);
            i_req = 1'b0; d_req = 1'b0;
        end
    endtask

    // Bus model: acks request beats after ack_delay cycles, returns fill data (addr>>8)+k.
    initial begin
        int wait_cnt;
        bit prev_accept;
        logic [T-1:0] prev_tag;
        logic [W-1:0] prev_addr, rbase;
        int gap_cnt;
        wait_cnt = 0; prev_accept = 1'b0; prev_tag = '0; prev_addr = '0; rbase = '0; gap_cnt = 0;
        bif.bus_reqack = 1'b0; bif.bus_respcyc = 1'b0; bif.bus_resp = '0; bif.bus_resptag = '0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                bif.bus_reqack = 1'b0; bif.bus_respcyc = 1'b0;
                slave_in_resp = 1'b0; slave_rbeat = 0; wait_cnt = 0;
            end else begin
                if (prev_accept && prev_tag[T-1]) begin
                    slave_in_resp = 1'b1; slave_rbeat = 0; gap_cnt = 0; rbase = prev_addr >> 8;
                end
                if (bif.bus_reqcyc && !slave_in_resp) begin
                    if (wait_cnt >= ack_delay) begin bif.bus_reqack = 1'b1; wait_cnt = 0; end
                    else begin bif.bus_reqack = 1'b0; wait_cnt++; end
                end else begin
                    bif.bus_reqack = 1'b0;
                end
                if (slave_in_resp) begin
                    if (slave_rbeat == BEATS) begin
                        slave_in_resp = 1'b0; bif.bus_respcyc = 1'b0;
                    end else if (slave_rbeat == gap_at && gap_cnt < gap_len) begin
                        bif.bus_respcyc = 1'b0; gap_cnt++;
                    end else begin
                        bif.bus_respcyc = 1'b1; bif.bus_resp = rbase + 64'(slave_rbeat); slave_rbeat++;
                    end
                end else begin
                    bif.bus_respcyc = stray_resp; bif.bus_resp = 64'hDEAD_BEEF_0000_0001;
                end
            end
            prev_accept = bif.bus_reqack && bif.bus_reqcyc;
            prev_tag = bif.bus_reqtag;
            prev_addr = bif.bus_req;
        end
    end

    // Monitor: compares every accepted request beat and every valid pulse against the queues.
    initial begin
        bit prev_pending;
        logic [W-1:0] prev_req;
        bus_exp_t b;
        resp_exp_t r;
        prev_pending = 1'b0; prev_req = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_pending = 1'b0;
            end else begin
                if (bif.bus_reqcyc && prev_pending) check("req_stable_in_stall", bif.bus_req, prev_req);
                if (bif.bus_reqcyc && bif.bus_reqack) begin
                    if (bus_q.size() == 0) begin
                        checks++;
                        $display("FAIL bus_beat: got unexpected beat %0h required none", bif.bus_req);
                    end else begin
                        b = bus_q.pop_front();
                        check("bus_req", bif.bus_req, b.data);
                        check("bus_reqtag", bif.bus_reqtag, b.tag);
                    end
                end
                prev_pending = bif.bus_reqcyc && !bif.bus_reqack;
                prev_req = bif.bus_req;
                if (slave_in_resp) check("respack_follows_respcyc", bif.bus_respack, bif.bus_respcyc);
                if (i_valid || d_valid) begin
                    if (i_valid && d_valid) begin
                        checks++;
                        $display("FAIL valid_both: got i=1 d=1 required one");
                    end else if (resp_q.size() == 0) begin
                        checks++;
                        $display("FAIL valid_pulse: got unexpected i=%0d d=%0d required none", i_valid, d_valid);
                    end else begin
                        r = resp_q.pop_front();
                        check("valid_client_is_d", d_valid, r.is_d);
                        check("blk_data", blk_data, r.blk);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        bit any_valid;
        reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_i_valid", i_valid, 0);
        check("rst_d_valid", d_valid, 0);
        check("rst_reqcyc", bif.bus_reqcyc, 0);
        check("rst_respack", bif.bus_respack, 0);
        check("rst_req", bif.bus_req, 0);
        check("rst_reqtag", bif.bus_reqtag, 0);
        check("rst_blk", blk_data, 0);
        reset = 1'b0;

        // 1: icache fill, unaligned address, zero-stall latency
        @(posedge clk); #1;
        expect_txn(1'b0, 1'b0, 64'h1000, '0, 64'h10);
        i_addr = 64'h1007; i_req = 1'b1;
        wait_done(1'b1, 1'b0, lat);
        check("t1_fill_latency", lat, 11);

        // 2: dcache writeback
        @(posedge clk); #1;
        expect_txn(1'b1, 1'b1, 64'h2040, words(64'hA0), '0);
        d_addr = 64'h2040; d_we = 1'b1; d_wdata = words(64'hA0); d_req = 1'b1;
        wait_done(1'b0, 1'b1, lat);
        @(posedge clk); #1;
        check("t2_blk_unchanged", blk_data, words(64'h10));

        // 3: stalls on request and response channels
        ack_delay = 3;
        expect_txn(1'b1, 1'b1, 64'h2080, words(64'hB0), '0);
        d_addr = 64'h2080; d_we = 1'b1; d_wdata = words(64'hB0); d_req = 1'b1;
        wait_done(1'b0, 1'b1, lat);
        @(posedge clk); #1;
        gap_at = 4; gap_len = 2;
        expect_txn(1'b0, 1'b0, 64'h6000, '0, 64'h60);
        i_addr = 64'h6000; i_req = 1'b1;
        wait_done(1'b1, 1'b0, lat);
        ack_delay = 0; gap_at = 99; gap_len = 0;

        // 4: contention, tie 1 (icache served last, so dcache wins in both builds)
        @(posedge clk); #1;
        expect_txn(1'b1, 1'b0, 64'h3000, '0, 64'h30);
        expect_txn(1'b0, 1'b0, 64'h4000, '0, 64'h40);
        d_addr = 64'h3000; d_we = 1'b0; d_req = 1'b1;
        i_addr = 64'h4000; i_req = 1'b1;
        wait_done(1'b1, 1'b1, lat);
        // lone dcache writeback makes dcache the last served
        @(posedge clk); #1;
        expect_txn(1'b1, 1'b1, 64'h2100, words(64'hC0), '0);
        d_addr = 64'h2100; d_we = 1'b1; d_wdata = words(64'hC0); d_req = 1'b1;
        wait_done(1'b0, 1'b1, lat);
        // tie 2
        @(posedge clk); #1;
`ifdef ROUND_ROBIN_EN
        expect_txn(1'b0, 1'b0, 64'h7000, '0, 64'h70);
        expect_txn(1'b1, 1'b0, 64'h8000, '0, 64'h80);
`else
        expect_txn(1'b1, 1'b0, 64'h8000, '0, 64'h80);
        expect_txn(1'b0, 1'b0, 64'h7000, '0, 64'h70);
`endif
        d_addr = 64'h8000; d_we = 1'b0; d_req = 1'b1;
        i_addr = 64'h7000; i_req = 1'b1;
        wait_done(1'b1, 1'b1, lat);

        // 5: reset after response beat 4 abandons the fill
        @(posedge clk); #1;
        bus_q.push_back('{data: 64'h9000, tag: READ_TAG});
        i_addr = 64'h9000; i_req = 1'b1;
        lat = 0;
        while (slave_rbeat != 5 && lat < 100) begin @(negedge clk); lat++; end
        if (lat >= 100) begin checks++; $display("FAIL t5_wait_beat4: got timeout required beat 4"); end
        @(posedge clk); #2;
        reset = 1'b1; i_req = 1'b0;
        @(posedge clk); #2;
        check("t5_reqcyc", bif.bus_reqcyc, 0);
        check("t5_respack", bif.bus_respack, 0);
        check("t5_i_valid", i_valid, 0);
        check("t5_blk_cleared", blk_data, 0);
        reset = 1'b0;
        model_blk = '0;
        any_valid = 1'b0;
        repeat (12) begin @(posedge clk); #1; any_valid = any_valid | i_valid | d_valid; end
        check("t5_no_valid_pulse", any_valid, 0);
        expect_txn(1'b0, 1'b0, 64'hA000, '0, 64'hA0);
        i_addr = 64'hA000; i_req = 1'b1;
        wait_done(1'b1, 1'b0, lat);
        check("t5_refill_latency", lat, 11);

        // 6: stray response beat while idle
        @(posedge clk); #1;
        stray_resp = 1'b1;
        @(negedge clk); @(negedge clk);
        check("t6_stray_respack", bif.bus_respack, 0);
        @(posedge clk); #1;
        stray_resp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_blk_unchanged", blk_data, words(64'hA0));

        repeat (3) @(posedge clk);
        check("bus_q_drained", bus_q.size(), 0);
        check("resp_q_drained", resp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
